// File: rtl/lock_pkg.sv
// Shared types and helpers for the door-lock access controller:
// keypad packet type, nibble codes, FSM state enum and password checks.
package lock_pkg;

   // 20 nibbles; the last digit typed sits in [3:0], F marks an empty position
   typedef logic [19:0][3:0] senhaPac_t;

   localparam logic [3:0] NIB_EMPTY   = 4'hF;
   localparam logic [3:0] NIB_TIMEOUT = 4'hE;
   localparam logic [3:0] NIB_HASH    = 4'hB;

   localparam senhaPac_t PKT_EMPTY   = {20{NIB_EMPTY}};
   localparam senhaPac_t PKT_TIMEOUT = {20{NIB_TIMEOUT}};
   localparam senhaPac_t PKT_HASH    = {20{NIB_HASH}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_UNLOCKED,
      ST_WAIT_CLOSE,
      ST_FAIL,
      ST_LOCKOUT,
      ST_SETUP,
      ST_SETUP_SAVE
   } lock_state_t;

   function automatic int pw_len(input senhaPac_t p);
      int n;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (p[i] != NIB_EMPTY) n++;
      end
      return n;
   endfunction

   // Digits must be decimal and packed against the right edge with no holes
   function automatic logic pw_well_formed(input senhaPac_t p, input int min_d, input int max_d);
      logic ok;
      int   len;
      ok  = 1'b1;
      len = pw_len(p);
      for (int i = 0; i < 20; i++) begin
         if (p[i] != NIB_EMPTY && p[i] > 4'd9) ok = 1'b0;
      end
      for (int i = 1; i < 20; i++) begin
         if (p[i] != NIB_EMPTY && p[i-1] == NIB_EMPTY) ok = 1'b0;
      end
      if (len < min_d || len > max_d) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared down-counter: load a cycle count, count down to zero, and pulse
// done during the last counted cycle.
module lock_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   assign done = (count_reg == WIDTH'(1)) && !load;

endmodule

// File: rtl/lock_access_controller.sv
// Door-lock access sequencer: password check, bolt control, failure lockout
// and slot programming. Optional door-ajar alarm under DOOR_AJAR_ALARM_EN.
module lock_access_controller
   import lock_pkg::*;
#(
   parameter int        NUM_SLOTS      = 4,
   parameter int        MIN_DIGITS     = 4,
   parameter int        MAX_DIGITS     = 12,
   parameter int        MAX_FAILS      = 3,
   parameter int        UNLOCK_CYCLES  = 5000,
   parameter int        LOCKOUT_CYCLES = 30000,
   parameter int        AJAR_CYCLES    = 10000,
   parameter senhaPac_t MASTER_PW      = {64'hFFFF_FFFF_FFFF_FFFF, 16'h1234}
) (
   input  logic                             clk,
   input  logic                             rst,
   input  senhaPac_t                        digitos_value,
   input  logic                             digitos_valid,
   input  logic                             door_closed,
   output logic                             kbd_enable,
   output logic                             tranca,
   output logic                             bip,
   output logic                             setup_mode,
   output logic                             lockout,
   output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

   localparam int FC_W  = $clog2(MAX_FAILS + 1);
   localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int T_MAX_UL = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int T_MAX    = (T_MAX_UL > AJAR_CYCLES) ? T_MAX_UL : AJAR_CYCLES;
   localparam int TW       = $clog2(T_MAX + 1);

   lock_state_t      state_reg, state_next;
   senhaPac_t        pkt_reg;
   senhaPac_t        slot_reg [NUM_SLOTS];
   logic [PTR_W-1:0] write_ptr_reg;
   logic [FC_W-1:0]  fail_count_reg;
   logic [FC_W-1:0]  fail_inc;
   logic             setup_bip_reg;
   logic             ajar_bip;

   logic             timer_load;
   logic [TW-1:0]    timer_value;
   logic             timer_done;

   logic             is_attempt;
   logic             in_ok;
   logic             pkt_ok;
   logic [NUM_SLOTS-1:0] slot_hit;

   assign is_attempt = (digitos_value != PKT_TIMEOUT) && (digitos_value != PKT_HASH);
   assign in_ok      = pw_well_formed(digitos_value, MIN_DIGITS, MAX_DIGITS);
   assign pkt_ok     = pw_well_formed(pkt_reg, MIN_DIGITS, MAX_DIGITS);
   assign fail_inc   = (fail_count_reg == FC_W'(MAX_FAILS)) ? fail_count_reg
                                                            : fail_count_reg + FC_W'(1);

   // Empty slots hold all-F, which is never well formed, so they must not match
   generate
      for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_cmp
         assign slot_hit[gi] = (slot_reg[gi] != PKT_EMPTY) && (slot_reg[gi] == pkt_reg);
      end
   endgenerate

   lock_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .done       (timer_done)
   );

   always_comb begin
      state_next  = state_reg;
      timer_load  = 1'b0;
      timer_value = '0;
      case (state_reg)
         ST_IDLE: begin
            if (digitos_valid && is_attempt) state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (!pkt_ok) begin
               state_next = ST_FAIL;
            end else if (pkt_reg == MASTER_PW) begin
               state_next = ST_SETUP;
            end else if (|slot_hit) begin
               state_next  = ST_UNLOCKED;
               timer_load  = 1'b1;
               timer_value = TW'(UNLOCK_CYCLES);
            end else begin
               state_next = ST_FAIL;
            end
         end
         ST_UNLOCKED: begin
            if (!door_closed) begin
               state_next = ST_WAIT_CLOSE;
`ifdef DOOR_AJAR_ALARM_EN
               timer_load  = 1'b1;
               timer_value = TW'(AJAR_CYCLES);
`endif
            end else if (timer_done) begin
               state_next = ST_IDLE;
            end
         end
         ST_WAIT_CLOSE: begin
            if (door_closed) state_next = ST_IDLE;
         end
         ST_FAIL: begin
            if (fail_inc == FC_W'(MAX_FAILS)) begin
               state_next  = ST_LOCKOUT;
               timer_load  = 1'b1;
               timer_value = TW'(LOCKOUT_CYCLES);
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            if (timer_done) state_next = ST_IDLE;
         end
         ST_SETUP: begin
            if (digitos_valid) begin
               if (!is_attempt)  state_next = ST_IDLE;
               else if (in_ok)   state_next = ST_SETUP_SAVE;
            end
         end
         ST_SETUP_SAVE: state_next = ST_SETUP;
         default:       state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         pkt_reg        <= PKT_EMPTY;
         write_ptr_reg  <= '0;
         fail_count_reg <= '0;
         setup_bip_reg  <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) slot_reg[i] <= PKT_EMPTY;
      end else begin
         state_reg     <= state_next;
         setup_bip_reg <= (state_reg == ST_SETUP) && digitos_valid && is_attempt && !in_ok;
         if (digitos_valid && is_attempt && (state_reg == ST_IDLE || state_reg == ST_SETUP))
            pkt_reg <= digitos_value;
         if (state_reg == ST_CHECK && state_next == ST_UNLOCKED)
            fail_count_reg <= '0;
         else if (state_reg == ST_FAIL)
            fail_count_reg <= fail_inc;
         else if (state_reg == ST_LOCKOUT && timer_done)
            fail_count_reg <= '0;
         // Pointer wraps so a full table overwrites the oldest entry
         if (state_reg == ST_SETUP_SAVE) begin
            slot_reg[write_ptr_reg] <= pkt_reg;
            write_ptr_reg <= (write_ptr_reg == PTR_W'(NUM_SLOTS - 1)) ? '0
                                                                     : write_ptr_reg + PTR_W'(1);
         end
      end
   end

`ifdef DOOR_AJAR_ALARM_EN
   logic alarm_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alarm_reg <= 1'b0;
      end else begin
         alarm_reg <= (state_reg == ST_WAIT_CLOSE) && (state_next == ST_WAIT_CLOSE)
                      && (alarm_reg || timer_done);
      end
   end

   assign ajar_bip = alarm_reg && (state_reg == ST_WAIT_CLOSE);
`else
   assign ajar_bip = 1'b0;
`endif

   assign tranca     = !(state_reg == ST_UNLOCKED || state_reg == ST_WAIT_CLOSE);
   assign kbd_enable = (state_reg != ST_LOCKOUT);
   assign lockout    = (state_reg == ST_LOCKOUT);
   assign setup_mode = (state_reg == ST_SETUP) || (state_reg == ST_SETUP_SAVE);
   assign bip        = (state_reg == ST_FAIL) || setup_bip_reg || ajar_bip;
   assign fail_count = fail_count_reg;

endmodule

// File: tb/tb_lock_access_controller.sv
// Randomized self-checking bench for lock_access_controller against a
// password-table reference model; honours DOOR_AJAR_ALARM_EN for the alarm check.
module tb_lock_access_controller;
   import lock_pkg::*;

   localparam int UNLOCK_T  = 20;
   localparam int LOCKOUT_T = 40;
   localparam int AJAR_T    = 15;
   localparam int SLOTS     = 4;
   localparam int MAXF      = 3;
`ifdef DOOR_AJAR_ALARM_EN
   localparam bit AJAR_EN = 1'b1;
`else
   localparam bit AJAR_EN = 1'b0;
`endif

   localparam logic [79:0] ALL_F  = {20{4'hF}};
   localparam logic [79:0] ALL_E  = {20{4'hE}};
   localparam logic [79:0] ALL_B  = {20{4'hB}};
   localparam logic [79:0] MASTER = {64'hFFFF_FFFF_FFFF_FFFF, 16'h1234};
   localparam logic [79:0] P5678  = {64'hFFFF_FFFF_FFFF_FFFF, 16'h5678};
   localparam logic [79:0] P9999  = {64'hFFFF_FFFF_FFFF_FFFF, 16'h9999};
   localparam logic [79:0] P123   = {68'hF_FFFF_FFFF_FFFF_FFFF, 12'h123};
   localparam logic [79:0] P12A4  = {64'hFFFF_FFFF_FFFF_FFFF, 16'h12A4};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   senhaPac_t   digitos_value = ALL_F;
   logic        digitos_valid = 1'b0;
   logic        door_closed = 1'b1;
   logic        kbd_enable, tranca, bip, setup_mode, lockout;
   logic [1:0]  fail_count;

   int checks = 0;
   int failures = 0;
   int txn = 0;

   logic [79:0] m_slot [SLOTS];
   int          m_wp;
   int          m_fails;
   logic [79:0] setup_q [$];
   logic [79:0] setup_exit = '0;
   int          unlock_mode = 0;
   int          door_k = 0;

   lock_access_controller #(
      .NUM_SLOTS      (SLOTS),
      .MIN_DIGITS     (4),
      .MAX_DIGITS     (12),
      .MAX_FAILS      (MAXF),
      .UNLOCK_CYCLES  (UNLOCK_T),
      .LOCKOUT_CYCLES (LOCKOUT_T),
      .AJAR_CYCLES    (AJAR_T)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .digitos_value (digitos_value),
      .digitos_valid (digitos_valid),
      .door_closed   (door_closed),
      .kbd_enable    (kbd_enable),
      .tranca        (tranca),
      .bip           (bip),
      .setup_mode    (setup_mode),
      .lockout       (lockout),
      .fail_count    (fail_count)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Password = the run of nibbles from the right up to the first F; the rest must be F
   function automatic bit model_wf(input logic [79:0] p);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b1;
      while (n < 20 && p[4*n +: 4] != 4'hF) begin
         if (p[4*n +: 4] > 4'd9) ok = 1'b0;
         n++;
      end
      for (int i = n; i < 20; i++) begin
         if (p[4*i +: 4] != 4'hF) ok = 1'b0;
      end
      return ok && n >= 4 && n <= 12;
   endfunction

   function automatic bit model_hit(input logic [79:0] p);
      for (int i = 0; i < SLOTS; i++) begin
         if (m_slot[i] != ALL_F && m_slot[i] == p) return 1'b1;
      end
      return 1'b0;
   endfunction

   // kind: 0 well formed, 1 too short, 2 non-decimal digit, 3 hole, 4 too long
   function automatic logic [79:0] gen_pkt(input int kind);
      logic [79:0] p;
      int n;
      int j;
      p = ALL_F;
      case (kind)
         1:       n = $urandom_range(1, 3);
         4:       n = $urandom_range(13, 20);
         default: n = $urandom_range(4, 12);
      endcase
      for (int i = 0; i < n; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
      if (kind == 2) begin
         j = $urandom_range(0, n - 1);
         p[4*j +: 4] = 4'($urandom_range(10, 13));
      end
      if (kind == 3) begin
         j = $urandom_range(0, n - 2);
         p[4*j +: 4] = 4'hF;
      end
      return p;
   endfunction

   task automatic send_strobe(input logic [79:0] p);
      digitos_value = p;
      digitos_valid = 1'b1;
      tick();
      digitos_valid = 1'b0;
      digitos_value = ALL_F;
   endtask

   task automatic setup_session();
      int n;
      int kind;
      logic [79:0] p;
      n = (setup_q.size() > 0) ? setup_q.size() : $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
         if (setup_q.size() > 0) begin
            p = setup_q.pop_front();
         end else begin
            kind = $urandom_range(0, 5);
            if (kind == 5) kind = 0;
            p = gen_pkt(kind);
         end
         send_strobe(p);
         if (model_wf(p)) begin
            check_value("save_setup_mode", setup_mode, 1);
            tick();
            check_value("slot_write", dut.slot_reg[m_wp], p);
            m_slot[m_wp] = p;
            m_wp = (m_wp + 1) % SLOTS;
            check_value("write_ptr", dut.write_ptr_reg, m_wp);
         end else begin
            check_value("setup_bad_bip", bip, 1);
            tick();
            check_value("setup_bip_clear", bip, 0);
         end
         check_value("setup_stays", setup_mode, 1);
      end
      p = setup_exit;
      if (p == '0) p = ($urandom_range(0, 1) != 0) ? ALL_B : ALL_E;
      send_strobe(p);
      check_value("setup_exit", setup_mode, 0);
   endtask

   task automatic finish_unlock();
      int mode;
      int k;
      int n;
      mode = unlock_mode;
      if (mode == 0) mode = $urandom_range(1, 2);
      if (mode == 1) begin
         n = 0;
         while (tranca === 1'b0 && n < 200) begin
            n++;
            tick();
         end
         check_value("unlock_window", n, UNLOCK_T);
      end else begin
         k = door_k;
         if (k == 0) k = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 12) : $urandom_range(18, 25);
         door_closed = 1'b0;
         for (int i = 0; i < k; i++) begin
            tick();
            check_value("door_open_tranca", tranca, 0);
         end
         check_value("ajar_bip", bip, (AJAR_EN && k >= 17));
         door_closed = 1'b1;
         tick();
         check_value("close_tranca", tranca, 1);
         check_value("close_bip", bip, 0);
      end
   endtask

   task automatic run_lockout();
      int n;
      check_value("lockout_on", lockout, 1);
      check_value("lockout_kbd", kbd_enable, 0);
      n = 0;
      while (lockout === 1'b1 && n < 200) begin
         digitos_valid = (n == 5);
         digitos_value = (n == 5) ? MASTER : ALL_F;
         n++;
         tick();
      end
      digitos_valid = 1'b0;
      digitos_value = ALL_F;
      check_value("lockout_len", n, LOCKOUT_T);
      m_fails = 0;
      check_value("lockout_fails_clr", fail_count, 0);
      check_value("lockout_kbd_back", kbd_enable, 1);
      check_value("lockout_strobe_ignored", setup_mode, 0);
   endtask

   task automatic do_attempt(input logic [79:0] p);
      bit wf;
      bit master;
      bit hit;
      txn++;
      $display("txn %0d: pkt=%h fails=%0d", txn, p, m_fails);
      if (p == ALL_E || p == ALL_B) begin
         send_strobe(p);
         tick();
         check_value("ignored_tranca", tranca, 1);
         check_value("ignored_setup", setup_mode, 0);
         check_value("ignored_fails", fail_count, m_fails);
         return;
      end
      wf     = model_wf(p);
      master = wf && (p == MASTER);
      hit    = wf && !master && model_hit(p);
      send_strobe(p);
      check_value("check_tranca", tranca, 1);
      tick();
      if (master) begin
         check_value("setup_enter", setup_mode, 1);
         setup_session();
      end else if (hit) begin
         check_value("unlock_tranca", tranca, 0);
         check_value("unlock_fails_clr", fail_count, 0);
         m_fails = 0;
         finish_unlock();
      end else begin
         check_value("fail_bip", bip, 1);
         m_fails = (m_fails < MAXF) ? m_fails + 1 : MAXF;
         tick();
         check_value("fail_bip_clear", bip, 0);
         check_value("fail_count", fail_count, m_fails);
         if (m_fails == MAXF) run_lockout();
         else check_value("no_lockout", lockout, 0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      int idx;
      for (int i = 0; i < SLOTS; i++) m_slot[i] = ALL_F;
      m_wp = 0;
      m_fails = 0;

      tick();
      check_value("rst_tranca", tranca, 1);
      check_value("rst_kbd", kbd_enable, 1);
      tick();
      rst = 1'b0;
      tick();
      check_value("rst_bip", bip, 0);
      check_value("rst_setup", setup_mode, 0);
      check_value("rst_lockout", lockout, 0);
      check_value("rst_fails", fail_count, 0);
      check_value("rst_wptr", dut.write_ptr_reg, 0);
      check_value("rst_slot0", dut.slot_reg[0], ALL_F);

      // Program 5678 then leave with '#'
      setup_q.push_back(P5678);
      setup_exit = ALL_B;
      do_attempt(MASTER);
      setup_exit = '0;

      // Unlock with door cycle (long enough for the ajar alarm), then unlock window
      unlock_mode = 2;
      door_k = 20;
      do_attempt(P5678);
      unlock_mode = 1;
      do_attempt(P5678);
      unlock_mode = 0;
      door_k = 0;

      // Door opened while locked and idle changes nothing
      door_closed = 1'b0;
      tick(); tick(); tick();
      check_value("idle_door_tranca", tranca, 1);
      check_value("idle_door_setup", setup_mode, 0);
      door_closed = 1'b1;
      tick();

      do_attempt(P9999);
      do_attempt(P9999);
      do_attempt(P9999);

      do_attempt(ALL_E);
      do_attempt(P123);
      do_attempt(P12A4);

      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: do_attempt(MASTER);
            1, 5: begin
               idx = $urandom_range(0, SLOTS - 1);
               do_attempt((m_slot[idx] == ALL_F) ? gen_pkt(0) : m_slot[idx]);
            end
            2: do_attempt(gen_pkt($urandom_range(1, 4)));
            3: do_attempt(gen_pkt(0));
            default: do_attempt(($urandom_range(0, 1) != 0) ? ALL_E : ALL_B);
         endcase
      end

      // Asynchronous reset while unlocked
      setup_q.push_back(P5678);
      do_attempt(MASTER);
      txn++;
      $display("txn %0d: reset while unlocked", txn);
      send_strobe(P5678);
      tick();
      check_value("pre_rst_unlocked", tranca, 0);
      #2 rst = 1'b1;
      #1;
      check_value("arst_tranca", tranca, 1);
      check_value("arst_kbd", kbd_enable, 1);
      check_value("arst_bip", bip, 0);
      check_value("arst_setup", setup_mode, 0);
      check_value("arst_lockout", lockout, 0);
      check_value("arst_fails", fail_count, 0);
      check_value("arst_wptr", dut.write_ptr_reg, 0);
      for (int i = 0; i < SLOTS; i++) check_value("arst_slot", dut.slot_reg[i], ALL_F);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < SLOTS; i++) m_slot[i] = ALL_F;
      m_wp = 0;
      m_fails = 0;
      tick();
      do_attempt(P5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
